// File: rtl/cmp_pkg.sv
// Shared types for the registered magnitude comparator.
// Optional extended flags (ge/le/ne) are enabled by CMP_EXTENDED_FLAGS_EN.
package cmp_pkg;

    localparam int CMP_WIDTH_DEFAULT = 16;
    localparam int CMP_GROUP         = 4;

    typedef enum logic {
        CMP_UNSIGNED = 1'b0,
        CMP_SIGNED   = 1'b1
    } cmp_mode_e;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    // lt is implied: neither greater nor equal
    function automatic cmp_flags_t cmp_flags_make(
        input logic g,
        input logic e
    );
        cmp_flags_t f;
        f.gt = g;
        f.eq = e;
        f.lt = ~g & ~e;
        return f;
    endfunction

endpackage

// File: rtl/cmp_mag.sv
// Combinational unsigned magnitude comparator.
// Recursive split into 4-bit leaf groups; the upper half dominates.
module cmp_mag
    import cmp_pkg::*;
#(
    parameter int W = 15
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);

    if (W <= CMP_GROUP) begin : g_leaf
        assign gt = (a > b);
        assign eq = (a == b);
    end else begin : g_node
        // low half is a whole number of groups
        localparam int LO =
            ((W / 2 + CMP_GROUP - 1) / CMP_GROUP) * CMP_GROUP;
        localparam int HI = W - LO;

        logic hi_gt;
        logic hi_eq;
        logic lo_gt;
        logic lo_eq;

        cmp_mag #(.W(HI)) u_hi (
            .a  (a[W-1:LO]),
            .b  (b[W-1:LO]),
            .gt (hi_gt),
            .eq (hi_eq)
        );

        cmp_mag #(.W(LO)) u_lo (
            .a  (a[LO-1:0]),
            .b  (b[LO-1:0]),
            .gt (lo_gt),
            .eq (lo_eq)
        );

        assign gt = hi_gt | (hi_eq & lo_gt);
        assign eq = hi_eq & lo_eq;
    end

endmodule

// File: rtl/cmp_unit.sv
// Registered signed/unsigned comparator with one-hot gt/eq/lt flags.
// Define CMP_EXTENDED_FLAGS_EN to add registered ge/le/ne outputs.
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    output logic             out_valid,
    output logic             gt,
    output logic             eq,
`ifdef CMP_EXTENDED_FLAGS_EN
    output logic             ge,
    output logic             le,
    output logic             ne,
`endif
    output logic             lt
);

    cmp_mode_e  mode;
    logic       mag_gt;
    logic       mag_eq;
    logic       a_msb;
    logic       msb_diff;
    cmp_flags_t nxt;
    cmp_flags_t flags_q;
    logic       valid_q;

    assign mode     = cmp_mode_e'(sign);
    assign a_msb    = a[WIDTH-1];
    assign msb_diff = a[WIDTH-1] ^ b[WIDTH-1];

    cmp_mag #(.W(WIDTH-1)) u_mag (
        .a  (a[WIDTH-2:0]),
        .b  (b[WIDTH-2:0]),
        .gt (mag_gt),
        .eq (mag_eq)
    );

    // differing MSBs settle it: MSB=1 wins unsigned, loses signed
    always_comb begin
        nxt = '0;
        if (msb_diff) begin
            unique case (mode)
                CMP_SIGNED:   nxt = cmp_flags_make(~a_msb, 1'b0);
                CMP_UNSIGNED: nxt = cmp_flags_make(a_msb, 1'b0);
            endcase
        end else begin
            nxt = cmp_flags_make(mag_gt, mag_eq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            flags_q <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                flags_q <= nxt;
            end
        end
    end

    assign out_valid = valid_q;
    assign gt        = flags_q.gt;
    assign eq        = flags_q.eq;
    assign lt        = flags_q.lt;

`ifdef CMP_EXTENDED_FLAGS_EN
    logic [2:0] ext_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= '0;
        end else if (in_valid) begin
            ext_q <= {nxt.gt | nxt.eq, nxt.lt | nxt.eq, ~nxt.eq};
        end
    end

    assign ge = ext_q[2];
    assign le = ext_q[1];
    assign ne = ext_q[0];
`endif

endmodule

// File: tb/tb_cmp_unit.sv
// Scoreboard bench for cmp_unit: queue of expected flags, checked one
// cycle after each accepted operand pair.
module tb_cmp_unit;
    import cmp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        sign;
    logic        out_valid;
    logic        gt;
    logic        eq;
    logic        lt;
`ifdef CMP_EXTENDED_FLAGS_EN
    logic        ge;
    logic        le;
    logic        ne;
`endif

    cmp_flags_t  sb[$];
    cmp_flags_t  exp;
    cmp_flags_t  last;
    int          checks;
    int          errors;

    cmp_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .out_valid (out_valid),
        .gt        (gt),
        .eq        (eq),
`ifdef CMP_EXTENDED_FLAGS_EN
        .ge        (ge),
        .le        (le),
        .ne        (ne),
`endif
        .lt        (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic cmp_flags_t model(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic        s
    );
        cmp_flags_t f;
        f.eq = (x == y);
        if (s) f.gt = ($signed(x) > $signed(y));
        else   f.gt = (x > y);
        f.lt = !f.gt && !f.eq;
        return f;
    endfunction

    task automatic drive(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic        s
    );
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sign     = s;
        sb.push_back(model(x, y, s));
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sign     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            sign     = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, gt, eq, lt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: got v/gt/eq/lt=%b want 0000",
                     {out_valid, gt, eq, lt});
        end
`ifdef CMP_EXTENDED_FLAGS_EN
        checks++;
        if ({ge, le, ne} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ext: got %b want 000", {ge, le, ne});
        end
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        drive(16'd1, 16'd2, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        void'(sb.pop_front());
        checks++;
        if ({out_valid, gt, eq, lt} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_first: got v/gt/eq/lt=%b want 1001",
                     {out_valid, gt, eq, lt});
        end
        last = 3'b001;
    endtask

    task automatic test_compare;
        logic [15:0] va[19] = '{
            16'd2, 16'd1, 16'd256, 16'd257, 16'd256,
            16'd2, 16'hFFFF, 16'd257, 16'hFF00, 16'hFF00,
            16'hFEFF, 16'd2, 16'hFF00, 16'h8000, 16'h8000,
            16'hFFFF, 16'hFFFF, 16'h1234, 16'h8000};
        logic [15:0] vb[19] = '{
            16'd1, 16'd1, 16'd257, 16'd256, 16'd256,
            16'hFFFF, 16'd2, 16'hFF00, 16'd257, 16'hFEFF,
            16'hFF00, 16'hFFFF, 16'd257, 16'h7FFF, 16'h7FFF,
            16'h0000, 16'h0000, 16'h1234, 16'h8000};
        logic        vs[19] = '{
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
            1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i <= 19; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmp[%0d]: scoreboard empty", i - 1);
                end else begin
                    exp = sb.pop_front();
                    checks++;
                    if (out_valid !== 1'b1 || {gt, eq, lt} !== exp) begin
                        errors++;
                        $display("FAIL cmp[%0d]: got v=%b gel=%b want v=1 gel=%b",
                                 i - 1, out_valid, {gt, eq, lt}, exp);
                    end
`ifdef CMP_EXTENDED_FLAGS_EN
                    checks++;
                    if ({ge, le, ne} !==
                        {exp.gt | exp.eq, exp.lt | exp.eq, ~exp.eq}) begin
                        errors++;
                        $display("FAIL cmp_ext[%0d]: got gln=%b want %b",
                                 i - 1, {ge, le, ne},
                                 {exp.gt | exp.eq, exp.lt | exp.eq, ~exp.eq});
                    end
`endif
                    last = exp;
                end
            end
            if (i < 19) drive(va[i], vb[i], vs[i]);
            else        in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b[%0d]: scoreboard empty", i - 1);
                end else begin
                    exp = sb.pop_front();
                    checks++;
                    if (out_valid !== 1'b1 || {gt, eq, lt} !== exp ||
                        !$onehot({gt, eq, lt})) begin
                        errors++;
                        $display("FAIL b2b[%0d]: got v=%b gel=%b want v=1 gel=%b",
                                 i - 1, out_valid, {gt, eq, lt}, exp);
                    end
                    last = exp;
                end
            end
            if (i < 12) begin
                if (i % 4 == 3) drive(16'($urandom), 16'hA5A5, 1'($urandom));
                else            drive(16'($urandom), 16'($urandom), 1'($urandom));
                if (i % 4 == 3) a = 16'hA5A5;
                if (i % 4 == 3) sb[sb.size() - 1] = model(a, b, sign);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_idle;
        @(negedge clk);
        drive(16'hFF00, 16'd257, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'd1;
        b        = 16'd2;
        sign     = 1'b0;
        exp      = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {gt, eq, lt} !== exp) begin
            errors++;
            $display("FAIL idle_pre: got v=%b gel=%b want v=1 gel=%b",
                     out_valid, {gt, eq, lt}, exp);
        end
        last = exp;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || {gt, eq, lt} !== last) begin
                errors++;
                $display("FAIL idle_hold: got v=%b gel=%b want v=0 gel=%b",
                         out_valid, {gt, eq, lt}, last);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive(16'hFF00, 16'hFEFF, 1'b1);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({out_valid, gt, eq, lt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: got v/gt/eq/lt=%b want 0000",
                     {out_valid, gt, eq, lt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, gt, eq, lt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_stale: got v/gt/eq/lt=%b want 0000",
                     {out_valid, gt, eq, lt});
        end
        drive(16'hFF00, 16'hFEFF, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        exp      = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {gt, eq, lt} !== exp) begin
            errors++;
            $display("FAIL reset_recover: got v=%b gel=%b want v=1 gel=%b",
                     out_valid, {gt, eq, lt}, exp);
        end
`ifdef CMP_EXTENDED_FLAGS_EN
        checks++;
        if ({ge, le, ne} !== 3'b101) begin
            errors++;
            $display("FAIL reset_recover_ext: got gln=%b want 101",
                     {ge, le, ne});
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last   = '0;
        test_reset();
        test_compare();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
